// File: rtl/zone_fire_scheduler.sv
// Engagement sequencer for the 9-zone turret: measure, then aim/dwell/fire/cool
// each detected zone round-robin, in single-sweep or continuous chase operation.
module zone_fire_scheduler #(
    parameter int NZ           = 9,
    parameter int ZW           = 4,
    parameter int CW           = 16,
    parameter int DWELL_CYC    = 1000,
    parameter int FIRE_CYC     = 4,
    parameter int COOLDOWN_CYC = 2000
) (
    input  logic          fclk,
    input  logic          reset,
    input  logic          enable,
    input  logic          mode_chase,
    input  logic          start,
    output logic          meas_start,
    input  logic          meas_done,
    input  logic [NZ-1:0] meas_mask,
    output logic          aim_valid,
    output logic [ZW-1:0] aim_zone,
    input  logic          aim_ready,
    output logic          fire,
    output logic          busy,
    output logic [7:0]    hit_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] MEASURE = 3'd1;
    localparam logic [2:0] PICK    = 3'd2;
    localparam logic [2:0] AIM     = 3'd3;
    localparam logic [2:0] DWELL   = 3'd4;
    localparam logic [2:0] FIRE    = 3'd5;
    localparam logic [2:0] COOL    = 3'd6;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] FIRE_LAST  = CW'(FIRE_CYC - 1);
    localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN_CYC - 1);

    logic [2:0]    state;
    logic [2:0]    state_d;
    logic [NZ-1:0] pending;
    logic [ZW-1:0] ptr;
    logic [ZW-1:0] pick_zone;
    logic          pick_found;
    logic [CW-1:0] cnt;
    logic          abort;

    // Zone index base+off, wrapping modulo NZ (off is always < NZ).
    function automatic logic [ZW-1:0] wrap_idx(input logic [ZW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NZ) s = s - NZ;
        return ZW'(s);
    endfunction

    assign abort = (state != IDLE) && !enable;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        pick_zone  = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NZ; i++) begin
            if (!pick_found && pending[wrap_idx(ptr, i)]) begin
                pick_found = 1'b1;
                pick_zone  = wrap_idx(ptr, i);
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (enable && (start || mode_chase)) state_d = MEASURE;
            MEASURE: if (meas_done) state_d = (meas_mask != '0) ? PICK : IDLE;
            PICK:    state_d = pick_found ? AIM : IDLE;
            AIM:     if (aim_valid && aim_ready) state_d = DWELL;
            DWELL:   if (cnt == DWELL_LAST) state_d = FIRE;
            FIRE:    if (cnt == FIRE_LAST) state_d = COOL;
            COOL:    if (cnt == COOL_LAST) state_d = (pending != '0) ? PICK : IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the pre-edge values.
    always_ff @(posedge fclk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            meas_start <= 1'b0;
            aim_valid  <= 1'b0;
            aim_zone   <= '0;
            fire       <= 1'b0;
            hit_count  <= '0;
            pending    <= '0;
            ptr        <= '0;
            cnt        <= '0;
        end else begin
            state      <= state_d;
            busy       <= (state_d != IDLE);
            meas_start <= (state == IDLE) && (state_d == MEASURE);
            aim_valid  <= (state_d == AIM);
            fire       <= (state_d == FIRE);
            // Counter restarts on every state entry; only the timed states read it.
            if ((state_d != state) || (state_d == IDLE)) cnt <= '0;
            else cnt <= cnt + 1'b1;

            if (abort) begin
                pending <= '0;
            end else begin
                case (state)
                    MEASURE: if (meas_done) pending <= meas_mask;
                    PICK:    aim_zone <= pick_zone;
                    FIRE: begin
                        if (cnt == FIRE_LAST) begin
                            pending[aim_zone] <= 1'b0;
                            ptr               <= wrap_idx(aim_zone, 1);
                            if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_zone_fire_scheduler.sv
// Directed bench for zone_fire_scheduler with short dwell/fire/cool timing;
// expected zone orders and cycle positions are written out by hand.
module tb_zone_fire_scheduler;

    localparam int NZ = 9;
    localparam int ZW = 4;
    localparam int D  = 3;
    localparam int F  = 4;
    localparam int C  = 5;

    logic          fclk = 1'b0;
    logic          reset;
    logic          enable;
    logic          mode_chase;
    logic          start;
    logic          meas_start;
    logic          meas_done;
    logic [NZ-1:0] meas_mask;
    logic          aim_valid;
    logic [ZW-1:0] aim_zone;
    logic          aim_ready;
    logic          fire;
    logic          busy;
    logic [7:0]    hit_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_hits = 0;

    zone_fire_scheduler #(
        .NZ(NZ), .ZW(ZW), .CW(16), .DWELL_CYC(D), .FIRE_CYC(F), .COOLDOWN_CYC(C)
    ) dut (
        .fclk(fclk), .reset(reset), .enable(enable), .mode_chase(mode_chase),
        .start(start), .meas_start(meas_start), .meas_done(meas_done),
        .meas_mask(meas_mask), .aim_valid(aim_valid), .aim_zone(aim_zone),
        .aim_ready(aim_ready), .fire(fire), .busy(busy), .hit_count(hit_count)
    );

    always #5 fclk = ~fclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    // Entered on the meas_start cycle; leaves on the first AIM cycle (non-empty mask)
    // or on the IDLE cycle (empty mask).
    task automatic do_measure(input logic [NZ-1:0] mask);
        check("meas_start_pulse", 32'(meas_start), 1);
        check("busy_measure", 32'(busy), 1);
        step();
        check("meas_start_once", 32'(meas_start), 0);
        meas_done = 1'b1;
        meas_mask = mask;
        step();
        meas_done = 1'b0;
        meas_mask = '0;
        if (mask != '0) begin
            check("pick_no_aim", 32'(aim_valid), 0);
            check("busy_pick", 32'(busy), 1);
            step();
        end else begin
            check("empty_to_idle", 32'(busy), 0);
            check("empty_no_fire", 32'(fire), 0);
        end
    endtask

    // Entered on the first AIM cycle; leaves on the cycle after COOL.
    task automatic serve(input int zone, input int stall, input bit inject);
        check("aim_valid_rise", 32'(aim_valid), 1);
        check("aim_zone", 32'(aim_zone), 32'(zone));
        if (stall > 0) begin
            aim_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                step();
                check("stall_valid_held", 32'(aim_valid), 1);
                check("stall_zone_held", 32'(aim_zone), 32'(zone));
            end
        end
        aim_ready = 1'b1;
        step();
        for (int d = 0; d < D; d++) begin
            check("dwell_valid_low", 32'(aim_valid), 0);
            check("dwell_no_fire", 32'(fire), 0);
            check("dwell_busy", 32'(busy), 1);
            if (inject && d == 0) begin
                start     = 1'b1;
                meas_done = 1'b1;
                meas_mask = '0;
            end
            step();
            start     = 1'b0;
            meas_done = 1'b0;
        end
        for (int f = 0; f < F; f++) begin
            check("fire_high", 32'(fire), 1);
            check("fire_zone", 32'(aim_zone), 32'(zone));
            step();
        end
        if (exp_hits < 255) exp_hits++;
        check("fire_low_after", 32'(fire), 0);
        check("hit_count", 32'(hit_count), 32'(exp_hits));
        for (int c = 0; c < C; c++) begin
            check("cool_busy", 32'(busy), 1);
            check("cool_no_fire", 32'(fire), 0);
            step();
        end
    endtask

    // order holds zone k in nibble k; leaves on the IDLE cycle after the sweep.
    task automatic sweep(input logic [NZ-1:0] mask, input int n, input logic [35:0] order,
                         input int stall, input bit inject);
        do_measure(mask);
        for (int k = 0; k < n; k++) begin
            serve(int'(order[4*k +: 4]), stall, inject);
            if (k < n - 1) begin
                check("pick_gap_valid", 32'(aim_valid), 0);
                check("pick_gap_busy", 32'(busy), 1);
                step();
            end
        end
        check("sweep_idle", 32'(busy), 0);
    endtask

    task automatic single_sweep(input logic [NZ-1:0] mask, input int n, input logic [35:0] order,
                                input int stall);
        start = 1'b1;
        step();
        start = 1'b0;
        sweep(mask, n, order, stall, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        mode_chase = 1'b0;
        start      = 1'b0;
        meas_done  = 1'b0;
        meas_mask  = '0;
        aim_ready  = 1'b1;
        repeat (3) @(posedge fclk);
        #1;
        reset = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_meas_start", 32'(meas_start), 0);
        check("rst_aim_valid", 32'(aim_valid), 0);
        check("rst_aim_zone", 32'(aim_zone), 0);
        check("rst_fire", 32'(fire), 0);
        check("rst_hit_count", 32'(hit_count), 0);
        step();
        step();
        check("idle_stays", 32'(busy), 0);

        // 1: single sweep, zones 1 then 4
        single_sweep(9'b000010010, 2, 36'h41, 0);
        check("t1_hits", 32'(hit_count), 2);

        // 2: ptr 5 -> zone 7 leaves ptr 8, then wrap order 8, 0, 1
        single_sweep(9'b010000000, 1, 36'h7, 0);
        single_sweep(9'b100000011, 3, 36'h108, 0);

        // 3: 50-cycle handshake stall on zone 2
        single_sweep(9'b000000100, 1, 36'h2, 50);

        // 4: chase with empty masks re-requests measurement each IDLE
        mode_chase = 1'b1;
        step();
        for (int r = 0; r < 4; r++) begin
            if (r == 3) mode_chase = 1'b0;
            do_measure('0);
            if (r < 3) step();
        end
        step();
        check("chase_off_no_meas", 32'(meas_start), 0);
        check("chase_off_idle", 32'(busy), 0);

        // 5: abort during the 2nd fire cycle on zone 5 (ptr is 3)
        start = 1'b1;
        step();
        start = 1'b0;
        do_measure(9'b001100000);
        check("t5_aim_zone", 32'(aim_zone), 5);
        step();
        repeat (D) step();
        check("t5_fire1", 32'(fire), 1);
        step();
        check("t5_fire2", 32'(fire), 1);
        enable = 1'b0;
        step();
        check("abort_fire_low", 32'(fire), 0);
        check("abort_idle", 32'(busy), 0);
        check("abort_valid_low", 32'(aim_valid), 0);
        check("abort_hits_kept", 32'(hit_count), 32'(exp_hits));
        enable = 1'b1;
        step();
        step();
        check("abort_stays_idle", 32'(busy), 0);
        check("abort_no_meas", 32'(meas_start), 0);
        // ptr kept at 3 through the abort: order 5 then 2
        single_sweep(9'b000100100, 2, 36'h25, 0);

        // 6: chase all zones to saturate hit_count, with stray pulses while busy
        mode_chase = 1'b1;
        step();
        for (int s = 0; s < 34; s++) begin
            if (s == 33) mode_chase = 1'b0;
            sweep(9'h1FF, 9, 36'h210876543, 0, 1'b1);
            if (s < 33) step();
        end
        step();
        check("sat_hits", 32'(hit_count), 255);
        check("sat_idle", 32'(busy), 0);
        check("sat_no_meas", 32'(meas_start), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/zone_fire_scheduler.md
Name: zone_fire_scheduler

Overview:
- Sequences the turret's engagement loop around the 9-zone detection accumulator.
- Requests a measurement window and latches the resulting zone mask.
- Services each detected zone round-robin: aim handshake to the servo driver, dwell, fire pulse, then cooldown.
- Sits between the detection buffer and the servo/trigger drivers. Single-shot or continuous (chase) operation.

Parameters:
NZ, 9, number of detection zones (mask width)
ZW, 4, zone index width, ceil(log2(NZ))
CW, 16, dwell/fire/cooldown counter width
DWELL_CYC, 1000, cycles held after aim handshake before firing (must be >= 1)
FIRE_CYC, 4, fire pulse length in cycles (must be >= 1)
COOLDOWN_CYC, 2000, cycles after fire before next target (must be >= 1)

Ports:
fclk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  master enable; low aborts any operation
mode_chase  input  1  1 = restart measurement automatically whenever IDLE; 0 = one sweep per start
start  input  1  single-cycle pulse, begins a sweep in single mode
meas_start  output  1  one-cycle pulse requesting a new measurement window
meas_done  input  1  one-cycle pulse, meas_mask valid this cycle
meas_mask  input  NZ  detected-zone mask from accumulator
aim_valid  output  1  aim request to servo driver
aim_zone  output  ZW  zone index being aimed/fired
aim_ready  input  1  servo driver accepts aim request
fire  output  1  trigger drive
busy  output  1  high in every state except IDLE
hit_count  output  8  saturating count of fire events since reset

Behaviour:
- All outputs are registered. Reset (sampled on fclk) clears state to IDLE and zeroes every output, pending mask, rr pointer and counters.
- FSM states: IDLE, MEASURE, PICK, AIM, DWELL, FIRE, COOL.
- IDLE:
  - If enable && (start || mode_chase) -> MEASURE. meas_start is high exactly one cycle, the cycle after the condition.
  - start outside IDLE is ignored.
- MEASURE:
  - Waits for meas_done, with no timeout. meas_done outside MEASURE is ignored.
  - On meas_done: pending <= meas_mask.
  - Mask != 0 -> PICK. Mask == 0 -> IDLE.
- PICK (1 cycle):
  - Selects the first set pending bit at index >= ptr, searching upward and wrapping from NZ-1 to 0.
  - Loads aim_zone and goes to AIM. aim_valid asserts on entry to AIM.
  - meas_done cycle t -> aim_valid high at t+2.
- AIM:
  - aim_valid is held high, and aim_zone is held stable, until a cycle with aim_valid && aim_ready. That cycle is the transfer.
  - aim_valid drops the next cycle; state -> DWELL with counter = 0.
  - aim_ready while aim_valid is low has no effect.
- DWELL:
  - Exactly DWELL_CYC cycles, then -> FIRE.
- FIRE:
  - fire is high for exactly FIRE_CYC consecutive cycles.
  - On the last fire cycle:
    - clear pending[aim_zone]
    - ptr <= (aim_zone+1) mod NZ
    - hit_count increments, saturating at 255
  - Then -> COOL with fire low.
- COOL:
  - Exactly COOLDOWN_CYC cycles.
  - Then pending != 0 -> PICK; else -> IDLE.
  - In chase mode, IDLE immediately re-requests a measurement.
- Abort: enable low in any non-IDLE state -> IDLE on the next edge.
  - aim_valid, fire and meas_start go low that edge and pending clears.
  - ptr and hit_count are retained.
  - Abort during AIM is the only permitted withdrawal of aim_valid.
- mode_chase is sampled only in IDLE. Changing it mid-sweep affects only the next IDLE decision.
- aim_zone holds its last value in IDLE; reset value is 0.
- busy = (state != IDLE), registered with state.
- Counters are CW bits wide. Parameter values >= 2^CW are illegal.

Test Plan:
1. Reset then single sweep:
   - Stimulus: reset held 3 cycles, then release. start pulse at t; meas_done with mask 9'b000010010 (zones 1, 4); aim_ready tied high.
   - Required: meas_start at t+1; aim_zone 1 then 4; each fire is FIRE_CYC cycles, separated by DWELL+COOL timing; hit_count=2; returns to IDLE with busy=0.
2. Round-robin wrap:
   - Stimulus: after a sweep ending at zone 7 (ptr=8), a new sweep with mask 9'b100000011.
   - Required: service order 8, 0, 1.
3. Handshake stall:
   - Stimulus: aim_ready low for 50 cycles after aim_valid rises.
   - Required: aim_valid and aim_zone stable for all 50 cycles; transfer on the first ready cycle; DWELL starts the next cycle.
4. Empty mask and chase:
   - Stimulus: mode_chase=1 with meas_mask=0 repeatedly.
   - Required: meas_start re-pulses each time IDLE is re-entered; fire never asserts.
5. Abort mid-fire:
   - Stimulus: enable dropped during the 2nd fire cycle.
   - Required: fire low next cycle; IDLE; pending cleared; hit_count unchanged.
6. Saturation and ignored inputs:
   - Stimulus: 300 fire events; start/meas_done pulses injected while busy.
   - Required: hit_count stays at 255; the stray pulses have no effect.
